// File: rtl/bus_timer_slave_pkg.sv
// Shared bus and timer definitions for the memory-mapped timer slave.
package bus_timer_slave_pkg;

    typedef logic [1:0]  select_mode_t;
    typedef logic [31:0] mem_address_t;
    typedef logic [31:0] mem_byte_t;

    localparam select_mode_t SELECT_NONE  = 2'b00;
    localparam select_mode_t SELECT_SLAVE = 2'b10;

    typedef enum logic [1:0] {
        TIMER_CTRL     = 2'd0,
        TIMER_COUNT    = 2'd1,
        TIMER_CMP      = 2'd2,
        TIMER_PRESCALE = 2'd3
    } timer_reg_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_IE   = 1;
    localparam int unsigned CTRL_PEND = 2;

    typedef enum logic {
        BUS_IDLE,
        BUS_RESP
    } bus_state_e;

endpackage

// File: rtl/bus_timer_slave_timer_prescaler.sv
// Prescaler: free-running psc counter that emits a tick when it reaches prescale.
module timer_prescaler
    import bus_timer_slave_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  mem_byte_t   prescale,
    output logic        tick
);

    mem_byte_t psc;

    assign tick = en && (psc == prescale);

    // A prescale lowered below psc is not guarded: psc runs on to wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc <= '0;
        end else if (!en || clear || tick) begin
            psc <= '0;
        end else begin
            psc <= psc + 32'd1;
        end
    end

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped timer slave: register file, compare/pending logic and bus response FSM.
module bus_timer_slave
    import bus_timer_slave_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd0,
    parameter logic [31:0] CMP_RST      = 32'hFFFF_FFFF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  select_as_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    output logic [31:0] data_out,
    output logic        hold_flag_out,
    output logic        irq_out
);

    bus_state_e state_q, state_d;

    logic      en, ie, pend;
    mem_byte_t count, cmp, prescale;
    mem_byte_t rd_buf, rd_data;
    logic      tick, match;

    logic       accept, wr, rd;
    timer_reg_e reg_sel;
    logic       wr_ctrl, wr_count, wr_cmp, wr_prescale;
    logic       addr_unused;

    assign addr_unused = ^{addr_in[31:4], addr_in[1:0]};

    assign reg_sel     = timer_reg_e'(addr_in[3:2]);
    assign accept      = (state_q == BUS_IDLE) && (select_as_in == SELECT_SLAVE);
    assign wr          = accept && rw_in;
    assign rd          = accept && !rw_in;
    assign wr_ctrl     = wr && (reg_sel == TIMER_CTRL);
    assign wr_count    = wr && (reg_sel == TIMER_COUNT);
    assign wr_cmp      = wr && (reg_sel == TIMER_CMP);
    assign wr_prescale = wr && (reg_sel == TIMER_PRESCALE);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (wr_ctrl && !data_in[CTRL_EN]),
        .prescale (prescale),
        .tick     (tick)
    );

    assign match   = tick && (count == cmp);
    assign irq_out = ie && pend;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            TIMER_CTRL:     rd_data = {29'd0, pend, ie, en};
            TIMER_COUNT:    rd_data = count;
            TIMER_CMP:      rd_data = cmp;
            TIMER_PRESCALE: rd_data = prescale;
            default:        rd_data = '0;
        endcase
    end

    // Register writes take priority over tick updates; a compare match beats a pend clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            pend     <= 1'b0;
            count    <= '0;
            cmp      <= CMP_RST;
            prescale <= PRESCALE_RST;
        end else begin
            if (wr_ctrl) begin
                en <= data_in[CTRL_EN];
                ie <= data_in[CTRL_IE];
            end
            if (match) begin
                pend <= 1'b1;
            end else if (wr_ctrl && data_in[CTRL_PEND]) begin
                pend <= 1'b0;
            end
            if (wr_count) begin
                count <= data_in;
            end else if (match) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            if (wr_cmp) begin
                cmp <= data_in;
            end
            if (wr_prescale) begin
                prescale <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUS_IDLE;
            rd_buf  <= '0;
        end else begin
            state_q <= state_d;
            if (rd) begin
                rd_buf <= rd_data;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hold_flag_out = 1'b0;
        data_out      = '0;
        case (state_q)
            BUS_IDLE: begin
                if (rd) begin
                    hold_flag_out = 1'b1;
                    state_d       = BUS_RESP;
                end
            end
            BUS_RESP: begin
                data_out = rd_buf;
                state_d  = BUS_IDLE;
            end
            default: state_d = BUS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_timer_slave.sv
// Scoreboard bench for bus_timer_slave: directed scenarios plus random bus traffic.
module tb_bus_timer_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sel = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rw = 1'b0;
    logic [31:0] data_out;
    logic        hold;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model state: what the register map should hold right now.
    bit        m_en, m_ie, m_pend, m_busy;
    bit [31:0] m_count, m_cmp, m_pre, m_psc;

    bus_timer_slave #(.PRESCALE_RST(32'd0), .CMP_RST(32'hFFFF_FFFF)) dut (
        .clk           (clk),
        .rst           (rst),
        .select_as_in  (sel),
        .addr_in       (addr),
        .data_in       (wdata),
        .rw_in         (rw),
        .data_out      (data_out),
        .hold_flag_out (hold),
        .irq_out       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_en = 0; m_ie = 0; m_pend = 0; m_busy = 0;
        m_count = 0; m_cmp = 32'hFFFF_FFFF; m_pre = 0; m_psc = 0;
    endfunction

    function automatic bit [31:0] reg_value(input int unsigned idx);
        case (idx)
            0: return {29'd0, m_pend, m_ie, m_en};
            1: return m_count;
            2: return m_cmp;
            default: return m_pre;
        endcase
    endfunction

    function automatic bit match_now();
        return m_en && (m_psc == m_pre) && (m_count == m_cmp);
    endfunction

    // Advance the model across one rising edge with the given bus request.
    function automatic void model_edge(input bit [1:0] s, input bit [31:0] a, input bit [31:0] d, input bit w);
        int unsigned idx;
        bit acc, wr, tick, hit;
        bit [31:0] nxt_psc, nxt_count;
        bit nxt_pend;
        idx  = a[3:2];
        acc  = (s == 2'b10) && !m_busy;
        wr   = acc && w;
        if (acc && !w) exp_q.push_back(reg_value(idx));
        tick = m_en && (m_psc == m_pre);
        hit  = tick && (m_count == m_cmp);
        nxt_psc   = (!m_en || tick || (wr && idx == 0 && !d[0])) ? 32'd0 : m_psc + 32'd1;
        nxt_count = m_count;
        if (wr && idx == 1) nxt_count = d;
        else if (hit) nxt_count = 0;
        else if (tick) nxt_count = m_count + 32'd1;
        nxt_pend = m_pend;
        if (hit) nxt_pend = 1;
        else if (wr && idx == 0 && d[2]) nxt_pend = 0;
        if (wr && idx == 0) begin m_en = d[0]; m_ie = d[1]; end
        if (wr && idx == 2) m_cmp = d;
        if (wr && idx == 3) m_pre = d;
        m_psc = nxt_psc; m_count = nxt_count; m_pend = nxt_pend;
        m_busy = acc && !w;
    endfunction

    task automatic cycle(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d, input logic w);
        bit acc;
        @(negedge clk);
        sel = s; addr = a; wdata = d; rw = w;
        #1;
        acc = (s == 2'b10) && !m_busy;
        check("hold", {31'd0, hold}, {31'd0, acc && !w});
        check("irq", {31'd0, irq}, {31'd0, m_ie && m_pend});
        model_edge(s, a, d, w);
    endtask

    task automatic idle();
        cycle(2'b00, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic wr_reg(input int unsigned idx, input logic [31:0] d);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = idx[1:0];
        cycle(2'b10, a, d, 1'b1);
    endtask

    task automatic rd_reg(input int unsigned idx);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = idx[1:0];
        cycle(2'b10, a, 32'd0, 1'b0);
        idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        sel = 2'b00;
        #1;
        check("rst_data", data_out, 32'd0);
        check("rst_hold", {31'd0, hold}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    // Monitor: the cycle after a hold is the response cycle; otherwise data_out must be 0.
    initial begin
        bit prev;
        logic [31:0] exp;
        prev = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev = 0;
            end else begin
                if (prev) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rdata unexpected response %h", data_out);
                    end else begin
                        exp = exp_q.pop_front();
                        check("rdata", data_out, exp);
                    end
                end else begin
                    check("idle_data", data_out, 32'd0);
                end
                prev = hold;
            end
        end
    end

    initial begin
        int unsigned idx;
        logic [31:0] d;
        int n;
        model_reset();
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 4; i++) rd_reg(i);

        wr_reg(3, 32'd3);
        wr_reg(2, 32'd4);
        wr_reg(0, 32'd3);
        for (int i = 0; i < 8; i++) begin rd_reg(1); idle(); end
        rd_reg(0);

        wr_reg(0, 32'd7);
        rd_reg(0);
        n = 0;
        while (!match_now() && n < 200) begin idle(); n++; end
        if (!match_now()) begin
            checks++; errors++;
            $display("FAIL match_wait got timeout expected match tick");
        end
        wr_reg(0, 32'd7);
        rd_reg(0);

        wr_reg(3, 32'd0);
        wr_reg(2, 32'd5);
        wr_reg(0, 32'd7);
        wr_reg(1, 32'hFFFF_FFFE);
        cycle(2'b10, 32'h4, 32'd0, 1'b0);
        cycle(2'b10, 32'h4, 32'd0, 1'b0);
        cycle(2'b10, 32'h4, 32'd0, 1'b0);
        idle();
        rd_reg(0);
        wr_reg(1, 32'h100);
        rd_reg(1);

        wr_reg(3, 32'd3);
        wr_reg(0, 32'd3);
        idle(); idle();
        wr_reg(0, 32'd0);
        for (int i = 0; i < 6; i++) rd_reg(1);

        wr_reg(0, 32'd3);
        cycle(2'b11, 32'h4, 32'd0, 1'b0);
        cycle(2'b01, 32'h4, 32'd9, 1'b1);
        for (int i = 0; i < 400; i++) begin
            idx = $urandom_range(0, 3);
            case (idx)
                0: d = {29'd0, 3'($urandom_range(0, 7))};
                1: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom_range(0, 8);
                2: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 8);
                default: d = $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 5))
                0, 1: idle();
                2: cycle(2'b10 ^ 2'($urandom_range(1, 3)), $urandom, d, 1'($urandom));
                3: wr_reg(idx, d);
                default: cycle(2'b10, {$urandom} & 32'hFFFF_FFF3 | (idx << 2), d, 1'b0);
            endcase
        end

        wr_reg(0, 32'd3);
        cycle(2'b10, 32'h4, 32'd0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) rd_reg(i);

        repeat (3) idle();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
